// File: rtl/fetch_stage.sv
// fetch_stage: RV32 IF stage -- PC register, single-outstanding imem fetch, IF/ID register with one-entry skid.
// Optional FETCH_PERF_CNT_EN adds fetched-instruction and flush-cycle counters.
module fetch_stage #(
  parameter int              PC_W      = 9,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [31:0]     redirect_pc_i,
  output logic            imem_req_o,
  output logic [PC_W-1:0] imem_addr_o,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic            ifid_valid_o,
  output logic [PC_W-1:0] ifid_pc_o,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]     perf_fetch_cnt_o,
  output logic [31:0]     perf_flush_cnt_o,
`endif
  output logic [31:0]     ifid_instr_o
);
  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_e;
  state_e          state_q;
  logic [PC_W-1:0] pc_q, skid_pc_q, ifid_pc_q;
  logic [31:0]     skid_instr_q, ifid_instr_q;
  logic            skid_valid_q, ifid_valid_q;
  logic [PC_W-1:0] target, pc_inc;
  logic            accept;
  assign target = {redirect_pc_i[PC_W-1:2], 2'b00};
  assign pc_inc = pc_q + PC_W'(4);
  // a response is only usable when it lands in WAIT and is not flushed by a redirect
  assign accept      = state_q == WAIT && imem_rvalid_i && !redirect_i;
  assign imem_req_o  = rst_n && state_q == IDLE && !redirect_i && !stall_i && !skid_valid_q;
  assign imem_addr_o = pc_q;
  assign ifid_valid_o = ifid_valid_q;
  assign ifid_pc_o    = ifid_pc_q;
  assign ifid_instr_o = ifid_instr_q;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, flush_cnt_q;
  assign perf_fetch_cnt_o = fetch_cnt_q;
  assign perf_flush_cnt_o = flush_cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_q + 32'(!redirect_i && !stall_i && (skid_valid_q || accept));
      flush_cnt_q <= flush_cnt_q + 32'(redirect_i);
    end
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= '0;
      skid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP_INSTR;
    end else begin
      case (state_q)
        IDLE: if (redirect_i) pc_q <= target;
              else if (imem_req_o) state_q <= WAIT;
        WAIT: if (redirect_i) begin
                pc_q    <= target;
                state_q <= imem_rvalid_i ? IDLE : DROP;
              end else if (imem_rvalid_i) begin
                pc_q    <= pc_inc;
                state_q <= IDLE;
              end
        DROP: begin
                if (redirect_i) pc_q <= target;
                if (imem_rvalid_i) state_q <= IDLE;
              end
        default: state_q <= IDLE;
      endcase
      if (redirect_i) begin
        ifid_valid_q <= 1'b0;
        ifid_instr_q <= NOP_INSTR;
        skid_valid_q <= 1'b0;
      end else if (stall_i) begin
        if (accept) begin
          skid_valid_q <= 1'b1;
          skid_pc_q    <= pc_q;
          skid_instr_q <= imem_rdata_i;
        end
      end else if (skid_valid_q) begin
        ifid_valid_q <= 1'b1;
        ifid_pc_q    <= skid_pc_q;
        ifid_instr_q <= skid_instr_q;
        skid_valid_q <= 1'b0;
      end else if (accept) begin
        ifid_valid_q <= 1'b1;
        ifid_pc_q    <= pc_q;
        ifid_instr_q <= imem_rdata_i;
      end else begin
        ifid_valid_q <= 1'b0;
        ifid_instr_q <= NOP_INSTR;
      end
    end
endmodule
